// File: rtl/serial_adder_ctrl_v.sv
// Bit-serial adder controller.
// This file holds full_adder_v, a combinational 1-bit full adder, and
// serial_adder_ctrl_v, the controller that reuses that one adder for every
// bit position. The controller adds LSB-first, one bit per clock.
//
// serial_adder_ctrl_v ports:
//   i_clk   - system clock; all state changes on the rising edge
//   i_rst   - synchronous, active-high reset
//   i_start - request an addition; taken only while o_ready=1
//   i_a/i_b - WIDTH-bit operands, captured when a start is accepted
//   i_carry - carry-in, captured when a start is accepted
//   o_ready - high in IDLE and DONE
//   o_busy  - high while bits are being added
//   o_done  - one-cycle pulse; o_sum/o_carry are valid from this cycle
//   o_sum   - (A + B + cin) mod 2^WIDTH, held until the next result
//   o_carry - carry-out of bit WIDTH-1

// full_adder_v: purely combinational 1-bit full adder.
//   i_a, i_b, i_carry - addend bits and carry-in
//   o_sum, o_carry    - sum bit and carry-out
module full_adder_v (
  input  logic i_a,
  input  logic i_b,
  input  logic i_carry,
  output logic o_sum,
  output logic o_carry
);
  assign o_sum   = i_a ^ i_b ^ i_carry;
  assign o_carry = (i_a & i_b) | (i_carry & (i_a ^ i_b));
endmodule

module serial_adder_ctrl_v #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             c_reg;
  logic [CW-1:0]    cnt;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] s_next;

  full_adder_v u_fa (
    .i_a     (a_sh[0]),
    .i_b     (b_sh[0]),
    .i_carry (c_reg),
    .o_sum   (fa_sum),
    .o_carry (fa_carry)
  );

  // New sum bit enters at the MSB. Written as shifts rather than a part-select
  // so that WIDTH=1 needs no special case.
  always_comb begin
    s_next = (s_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      o_ready <= 1'b1;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_sum   <= '0;
      o_carry <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      s_sh    <= '0;
      c_reg   <= 1'b0;
      cnt     <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          o_done <= 1'b0;
          if (i_start) begin
            a_sh    <= i_a;
            b_sh    <= i_b;
            c_reg   <= i_carry;
            s_sh    <= '0;
            cnt     <= '0;
            state   <= ADD;
            o_ready <= 1'b0;
            o_busy  <= 1'b1;
          end else begin
            state   <= IDLE;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
          end
        end
        ADD: begin
          c_reg <= fa_carry;
          s_sh  <= s_next;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state   <= DONE;
            o_busy  <= 1'b0;
            o_ready <= 1'b1;
            o_done  <= 1'b1;
            o_sum   <= s_next;
            o_carry <= fa_carry;
          end
        end
        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
          o_busy  <= 1'b0;
          o_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl_v.sv
module tb_serial_adder_ctrl_v;

  logic       clk = 1'b0;
  logic       rst;

  logic       start8, cin8;
  logic [7:0] a8, b8;
  logic       ready8, busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start1, cin1;
  logic [0:0] a1, b1;
  logic       ready1, busy1, done1, cout1;
  logic [0:0] sum1;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl_v #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start8), .i_a(a8), .i_b(b8),
    .i_carry(cin8), .o_ready(ready8), .o_busy(busy8), .o_done(done8),
    .o_sum(sum8), .o_carry(cout8)
  );

  serial_adder_ctrl_v #(.WIDTH(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_a(a1), .i_b(b1),
    .i_carry(cin1), .o_ready(ready1), .o_busy(busy1), .o_done(done1),
    .o_sum(sum1), .o_carry(cout1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start one 8-bit addition, wait (bounded) for o_done; operand inputs are
  // scrambled after the accepting edge to show they were captured.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      output int lat, output int busy_cnt);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = cin;
    tick();
    start8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~cin;
    lat = 0; busy_cnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, dcnt;
    logic hold_ok;
    logic [2:0] v3;

    vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    tick(); tick();
    rst = 1'b0;

    check("reset_ready", 32'(ready8), 32'd1);
    check("reset_busy",  32'(busy8),  32'd0);
    check("reset_done",  32'(done8),  32'd0);
    check("reset_sum",   32'(sum8),   32'h00);
    check("reset_carry", 32'(cout8),  32'd0);

    // Table-driven 8-bit vectors
    for (int i = 0; i < 6; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].cin, lat, bcnt);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd8);
      check($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'd8);
      check($sformatf("v%0d_sum", i), 32'(sum8), 32'(vecs[i].sum));
      check($sformatf("v%0d_carry", i), 32'(cout8), 32'(vecs[i].cout));
      tick();
      check($sformatf("v%0d_done_pulse", i), 32'(done8), 32'd0);
      check($sformatf("v%0d_idle_ready", i), 32'(ready8), 32'd1);
    end

    // Start ignored during ADD: exactly one done, original operands used
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    tick();
    start8 = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 3) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; end
      if (c == 4) start8 = 1'b0;
      if (done8) dcnt++;
      tick();
    end
    check("ign_done_count", 32'(dcnt), 32'd1);
    check("ign_sum", 32'(sum8), 32'h30);
    check("ign_carry", 32'(cout8), 32'd0);

    // Back-to-back: start held in the DONE cycle, no IDLE bubble
    run8(8'h03, 8'h04, 1'b0, lat, bcnt);
    check("b2b_first_sum", 32'(sum8), 32'h07);
    start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0;
    tick();
    start8 = 1'b0;
    check("b2b_busy", 32'(busy8), 32'd1);
    check("b2b_ready", 32'(ready8), 32'd0);
    lat = 1; hold_ok = 1'b1;
    while (!done8 && lat < 40) begin
      if (sum8 !== 8'h07) hold_ok = 1'b0;
      tick();
      lat++;
    end
    check("b2b_hold", 32'(hold_ok), 32'd1);
    check("b2b_latency", 32'(lat), 32'd9);
    check("b2b_sum", 32'(sum8), 32'h02);
    tick();

    // Reset during ADD aborts, clears result, no done pulse
    start8 = 1'b1; a8 = 8'h5A; b8 = 8'h33;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy",  32'(busy8),  32'd0);
    check("abort_ready", 32'(ready8), 32'd1);
    check("abort_done",  32'(done8),  32'd0);
    check("abort_sum",   32'(sum8),   32'h00);
    check("abort_carry", 32'(cout8),  32'd0);
    dcnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (done8) dcnt++;
      tick();
    end
    check("abort_no_done", 32'(dcnt), 32'd0);
    run8(8'h7F, 8'h01, 1'b0, lat, bcnt);
    check("post_abort_sum", 32'(sum8), 32'h80);
    check("post_abort_latency", 32'(lat), 32'd8);
    tick();

    // Reset and start together: reset wins
    rst = 1'b1; start8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
    tick();
    rst = 1'b0; start8 = 1'b0;
    check("rst_start_busy", 32'(busy8), 32'd0);
    check("rst_start_ready", 32'(ready8), 32'd1);
    tick();
    check("rst_start_stay_idle", 32'(busy8), 32'd0);

    // WIDTH=1 sweep over all input combinations
    for (int i = 0; i < 8; i++) begin
      v3 = 3'(i);
      start1 = 1'b1; a1 = v3[2]; b1 = v3[1]; cin1 = v3[0];
      tick();
      start1 = 1'b0;
      lat = 0;
      while (!done1 && lat < 10) begin
        tick();
        lat++;
      end
      check($sformatf("w1_%0d_latency", i), 32'(lat), 32'd1);
      check($sformatf("w1_%0d_result", i), 32'({cout1, sum1}),
            32'(v3[2]) + 32'(v3[1]) + 32'(v3[0]));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
